// File: rtl/load_align_if.sv
// Load-path bundle: request from execute, word reads to data memory, and the
// aligned result back toward writeback.
interface load_align_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  modport slave (
    input  req_valid, req_addr, req_size, req_unsigned, mem_rd_data, resp_ready,
    output req_ready, mem_rd_en, mem_addr, resp_valid, resp_data, resp_err
  );

  modport master (
    output req_valid, req_addr, req_size, req_unsigned, mem_rd_data, resp_ready,
    input  req_ready, mem_rd_en, mem_addr, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/load_align_unit.sv
// Load aligner: issues one or two word reads to a synchronous memory, splits
// word-crossing accesses, and returns the little-endian, sign/zero-extended result.
module load_align_unit #(
  parameter int DATA_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  load_align_if.slave  bus,
  output logic [2:0]   state_dbg
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // req_ready is high only in IDLE; resp_valid is high only in RESP and its payload
  // holds until the transfer. Memory data is valid exactly one cycle after mem_rd_en.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    WT0  = 3'd2,
    RD1  = 3'd3,
    WT1  = 3'd4,
    RESP = 3'd5
  } state_t;

  state_t            state;
  logic [OFF_W-1:0]  off_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              cross_q;
  logic [DATA_W-1:0] lo_q;

  logic [4:0]          req_end;
  logic                req_cross;
  logic                req_illegal;
  logic [2*DATA_W-1:0] pair;
  logic [DATA_W-1:0]   assembled;

  assign state_dbg = state;

  assign req_end     = 5'(bus.req_addr[OFF_W-1:0]) + (5'd1 << bus.req_size);
  assign req_cross   = req_end > 5'(BYTES);
  assign req_illegal = (bus.req_size == 2'd3) && (DATA_W < 64);

  function automatic logic [DATA_W-1:0] assemble(
    input logic [2*DATA_W-1:0] p,
    input logic [OFF_W-1:0]    off,
    input logic [1:0]          size,
    input logic                uns
  );
    logic [2*DATA_W-1:0] shifted;
    logic                fill;
    logic [DATA_W-1:0]   r;
    int                  nbits;
    shifted = p >> {off, 3'b000};
    nbits   = 8 << size;
    case (size)
      2'd0:    fill = shifted[7];
      2'd1:    fill = shifted[15];
      2'd2:    fill = shifted[31];
      default: fill = shifted[63];
    endcase
    if (uns) fill = 1'b0;
    for (int i = 0; i < DATA_W; i++) r[i] = (i < nbits) ? shifted[i] : fill;
    return r;
  endfunction

  // The high word only exists after the second read; otherwise the upper half is zero.
  always_comb begin
    pair = {{DATA_W{1'b0}}, bus.mem_rd_data};
    if (state == WT1) pair = {bus.mem_rd_data, lo_q};
    assembled = assemble(pair, off_q, size_q, uns_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.req_ready  <= 1'b1;
      bus.mem_rd_en  <= 1'b0;
      bus.mem_addr   <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_err   <= 1'b0;
      off_q          <= '0;
      size_q         <= '0;
      uns_q          <= 1'b0;
      cross_q        <= 1'b0;
      lo_q           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            off_q         <= bus.req_addr[OFF_W-1:0];
            size_q        <= bus.req_size;
            uns_q         <= bus.req_unsigned;
            cross_q       <= req_cross;
            bus.req_ready <= 1'b0;
            if (req_illegal || (req_cross && !ALLOW_MISALIGNED)) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_data  <= '0;
            end else begin
              state         <= RD0;
              bus.mem_rd_en <= 1'b1;
              bus.mem_addr  <= {bus.req_addr[DATA_W-1:OFF_W], {OFF_W{1'b0}}};
            end
          end
        end
        RD0: begin
          bus.mem_rd_en <= 1'b0;
          state         <= WT0;
        end
        WT0: begin
          lo_q <= bus.mem_rd_data;
          if (cross_q) begin
            state         <= RD1;
            bus.mem_rd_en <= 1'b1;
            bus.mem_addr  <= bus.mem_addr + DATA_W'(BYTES);
          end else begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_data  <= assembled;
          end
        end
        RD1: begin
          bus.mem_rd_en <= 1'b0;
          state         <= WT1;
        end
        WT1: begin
          state          <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_data  <= assembled;
        end
        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.req_ready  <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          bus.req_ready  <= 1'b1;
          bus.mem_rd_en  <= 1'b0;
          bus.resp_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: one instance splits misaligned loads,
// a second one flags them as errors; both share the same request stimulus.
module tb_load_align_unit;
  logic clk;
  logic rst;

  logic        sel;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_ready;
  logic [31:0] w100;
  logic [31:0] w104;

  logic [2:0] st_a;
  logic [2:0] st_b;

  load_align_if #(.DATA_W(32)) bus_a ();
  load_align_if #(.DATA_W(32)) bus_b ();

  load_align_unit #(.DATA_W(32), .ALLOW_MISALIGNED(1'b1)) u_split (
    .clk(clk), .rst(rst), .bus(bus_a), .state_dbg(st_a)
  );
  load_align_unit #(.DATA_W(32), .ALLOW_MISALIGNED(1'b0)) u_strict (
    .clk(clk), .rst(rst), .bus(bus_b), .state_dbg(st_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus_a.req_valid    = req_valid & ~sel;
  assign bus_b.req_valid    = req_valid & sel;
  assign bus_a.req_addr     = req_addr;
  assign bus_b.req_addr     = req_addr;
  assign bus_a.req_size     = req_size;
  assign bus_b.req_size     = req_size;
  assign bus_a.req_unsigned = req_unsigned;
  assign bus_b.req_unsigned = req_unsigned;
  assign bus_a.resp_ready   = resp_ready;
  assign bus_b.resp_ready   = resp_ready;

  logic        s_req_ready, s_mem_rd_en, s_resp_valid, s_resp_err;
  logic [31:0] s_mem_addr, s_resp_data;
  logic [2:0]  s_state;
  assign s_req_ready  = sel ? bus_b.req_ready  : bus_a.req_ready;
  assign s_mem_rd_en  = sel ? bus_b.mem_rd_en  : bus_a.mem_rd_en;
  assign s_mem_addr   = sel ? bus_b.mem_addr   : bus_a.mem_addr;
  assign s_resp_valid = sel ? bus_b.resp_valid : bus_a.resp_valid;
  assign s_resp_data  = sel ? bus_b.resp_data  : bus_a.resp_data;
  assign s_resp_err   = sel ? bus_b.resp_err   : bus_a.resp_err;
  assign s_state      = sel ? st_b : st_a;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return w100;
      32'h0000_0104: return w104;
      32'hFFFF_FFFC: return 32'hA1B2C3D4;
      32'h0000_0000: return 32'h55667788;
      default:       return 32'hDEADBEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus_a.mem_rd_en) bus_a.mem_rd_data <= mem_word(bus_a.mem_addr);
    if (bus_b.mem_rd_en) bus_b.mem_rd_data <= mem_word(bus_b.mem_addr);
  end

  // read log of the selected instance
  logic [31:0] rd_q[$];
  int          rd_cyc_q[$];
  int          ncyc = 0;
  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (s_mem_rd_en) begin
      rd_q.push_back(s_mem_addr);
      rd_cyc_q.push_back(ncyc);
    end
  end

  // scoreboard
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: issue one request, wait for the response, complete the handshake
  task automatic do_req(input logic s, input logic [31:0] a, input logic [1:0] sz,
                        input logic u, output logic [31:0] d, output logic e,
                        output int lat);
    @(negedge clk);
    sel          = s;
    req_addr     = a;
    req_size     = sz;
    req_unsigned = u;
    rd_q.delete();
    rd_cyc_q.delete();
    req_valid    = 1'b1;
    #1;
    chk("req_ready_idle", 32'(s_req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!s_resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("resp_valid_seen", 32'(s_resp_valid), 32'd1);
    d = s_resp_data;
    e = s_resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  typedef struct {
    logic        sel;
    logic [31:0] w104;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_nrd;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] aligned;
    logic [31:0] hold;
    logic        e;
    int          lat;
    int          nrd_before;

    vecs[0]  = '{1'b0, 32'h11223344, 32'h103, 2'd0, 1'b0, 32'hFFFFFFDD, 1'b0, 3, 1};
    vecs[1]  = '{1'b0, 32'h11223344, 32'h102, 2'd1, 1'b1, 32'h0000DDCC, 1'b0, 3, 1};
    vecs[2]  = '{1'b0, 32'h11223344, 32'h102, 2'd2, 1'b0, 32'h3344DDCC, 1'b0, 5, 2};
    vecs[3]  = '{1'b0, 32'h11223344, 32'h103, 2'd1, 1'b0, 32'h000044DD, 1'b0, 5, 2};
    vecs[4]  = '{1'b0, 32'h112233F4, 32'h103, 2'd1, 1'b0, 32'hFFFFF4DD, 1'b0, 5, 2};
    vecs[5]  = '{1'b0, 32'h11223344, 32'h100, 2'd2, 1'b0, 32'hDDCCBBAA, 1'b0, 3, 1};
    vecs[6]  = '{1'b0, 32'h11223344, 32'h101, 2'd0, 1'b1, 32'h000000BB, 1'b0, 3, 1};
    vecs[7]  = '{1'b0, 32'h11223344, 32'h101, 2'd0, 1'b0, 32'hFFFFFFBB, 1'b0, 3, 1};
    vecs[8]  = '{1'b0, 32'h11223344, 32'h100, 2'd1, 1'b0, 32'hFFFFBBAA, 1'b0, 3, 1};
    vecs[9]  = '{1'b0, 32'h11223344, 32'h103, 2'd2, 1'b1, 32'h223344DD, 1'b0, 5, 2};
    vecs[10] = '{1'b0, 32'h11223344, 32'h101, 2'd2, 1'b0, 32'h44DDCCBB, 1'b0, 5, 2};
    vecs[11] = '{1'b0, 32'h11223344, 32'h104, 2'd0, 1'b0, 32'h00000044, 1'b0, 3, 1};
    vecs[12] = '{1'b0, 32'h11223344, 32'h107, 2'd0, 1'b1, 32'h00000011, 1'b0, 3, 1};
    vecs[13] = '{1'b0, 32'h11223344, 32'h100, 2'd3, 1'b0, 32'h00000000, 1'b1, 1, 0};
    vecs[14] = '{1'b0, 32'h11223344, 32'hFFFFFFFE, 2'd2, 1'b1, 32'h7788A1B2, 1'b0, 5, 2};
    vecs[15] = '{1'b1, 32'h11223344, 32'h101, 2'd2, 1'b0, 32'h00000000, 1'b1, 1, 0};
    vecs[16] = '{1'b1, 32'h11223344, 32'h102, 2'd1, 1'b1, 32'h0000DDCC, 1'b0, 3, 1};
    vecs[17] = '{1'b1, 32'h11223344, 32'h103, 2'd1, 1'b0, 32'h00000000, 1'b1, 1, 0};
    vecs[18] = '{1'b1, 32'h11223344, 32'h100, 2'd2, 1'b0, 32'hDDCCBBAA, 1'b0, 3, 1};

    rst          = 1'b1;
    sel          = 1'b0;
    req_valid    = 1'b0;
    req_addr     = '0;
    req_size     = '0;
    req_unsigned = 1'b0;
    resp_ready   = 1'b0;
    w100         = 32'hDDCCBBAA;
    w104         = 32'h11223344;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_req_ready",  32'(s_req_ready),  32'd1);
      chk("rst_mem_rd_en",  32'(s_mem_rd_en),  32'd0);
      chk("rst_mem_addr",   s_mem_addr,        32'd0);
      chk("rst_resp_valid", 32'(s_resp_valid), 32'd0);
      chk("rst_resp_data",  s_resp_data,       32'd0);
      chk("rst_resp_err",   32'(s_resp_err),   32'd0);
    end

    for (int i = 0; i < NV; i++) begin
      w104 = vecs[i].w104;
      exp_q.push_back(vecs[i].exp_data);
      do_req(vecs[i].sel, vecs[i].addr, vecs[i].size, vecs[i].uns, d, e, lat);
      chk($sformatf("v%0d_data", i), d, exp_q.pop_front());
      chk($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_reads", i), 32'(rd_q.size()), 32'(vecs[i].exp_nrd));
      aligned = vecs[i].addr & ~32'h3;
      if (vecs[i].exp_nrd >= 1 && rd_q.size() >= 1)
        chk($sformatf("v%0d_addr0", i), rd_q[0], aligned);
      if (vecs[i].exp_nrd == 2 && rd_q.size() == 2) begin
        chk($sformatf("v%0d_addr1", i), rd_q[1], aligned + 32'd4);
        chk($sformatf("v%0d_read_gap", i), 32'(rd_cyc_q[1] - rd_cyc_q[0]), 32'd2);
      end
    end
    w104 = 32'h11223344;

    // backpressure: response held while a new request is offered
    @(negedge clk);
    sel = 1'b0; req_addr = 32'h102; req_size = 2'd2; req_unsigned = 1'b0;
    rd_q.delete(); rd_cyc_q.delete();
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!s_resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    hold = s_resp_data;
    chk("bp_first_data", hold, 32'h3344DDCC);
    nrd_before = rd_q.size();
    req_addr = 32'h100; req_size = 2'd0; req_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_resp_valid", 32'(s_resp_valid), 32'd1);
      chk("bp_data_stable", s_resp_data, 32'h3344DDCC);
      chk("bp_req_ready", 32'(s_req_ready), 32'd0);
    end
    chk("bp_no_new_read", 32'(rd_q.size()), 32'(nrd_before));
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bp_after_ready", 32'(s_req_ready), 32'd1);
    chk("bp_after_valid", 32'(s_resp_valid), 32'd0);

    // reset during the second read of a crossing access
    @(negedge clk);
    req_addr = 32'h102; req_size = 2'd2; req_unsigned = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rd1_state", 32'(s_state), 32'd3);
    chk("rd1_mem_rd_en", 32'(s_mem_rd_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_state", 32'(s_state), 32'd0);
    chk("mid_rst_mem_rd_en", 32'(s_mem_rd_en), 32'd0);
    chk("mid_rst_resp_valid", 32'(s_resp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(s_req_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("post_rst_resp_valid", 32'(s_resp_valid), 32'd0);
    chk("post_rst_state", 32'(s_state), 32'd0);

    exp_q.push_back(32'hFFFFFFBB);
    do_req(1'b0, 32'h101, 2'd0, 1'b0, d, e, lat);
    chk("post_rst_data", d, exp_q.pop_front());
    chk("post_rst_latency", 32'(lat), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
